// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32I/RV64I immediate generator with a registered output
// stage and a 2-entry (main + skid) valid/ready buffer.
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; instr, src, in_tag are the payload
//   out_valid/out_ready  output handshake; out_imm, out_tag, out_err are the payload
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    localparam int unsigned IMM_W = 32;

    // Encoding chosen so out_valid and the full flag are plain state bits.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t state, state_n;

    logic [IMM_W-1:0] imm32;
    logic             err_c;
    logic [XLEN-1:0]  imm_ext;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    // Opcode bits never feed an immediate.
    logic             unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Immediate extraction, sign-extended to 32 bits (Z stays zero-extended).
    always_comb begin
        imm32 = '0;
        err_c = 1'b0;
        case (src)
            3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            3'b011:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            3'b100:  imm32 = {instr[31:12], 12'b0};
            3'b101:  imm32 = {27'b0, instr[19:15]};
            default: err_c = 1'b1;
        endcase
    end

    // Widen to XLEN; bit 31 is already the correct fill for every format.
    generate
        if (XLEN > IMM_W) begin : g_wide
            assign imm_ext = {{(XLEN-IMM_W){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm_ext = imm32;
        end
    endgenerate

    // Ready comes from the state register only; rst masks it so nothing is accepted.
    assign in_ready  = ~state[1] & ~rst;
    assign out_valid = state[0];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Occupancy FSM: next state and buffer load enables.
    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_n      = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (out_fire) begin
                    state_n = EMPTY;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end
            end
            FULL: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_n        = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // State and payload registers; main registers drive the outputs directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            out_imm  <= '0;
            out_tag  <= '0;
            out_err  <= 1'b0;
            skid_imm <= '0;
            skid_tag <= '0;
            skid_err <= 1'b0;
        end else begin
            state <= state_n;
            if (load_main_in) begin
                out_imm <= imm_ext;
                out_tag <= in_tag;
                out_err <= err_c;
            end else if (load_main_skid) begin
                out_imm <= skid_imm;
                out_tag <= skid_tag;
                out_err <= skid_err;
            end
            if (load_skid) begin
                skid_imm <= imm_ext;
                skid_tag <= in_tag;
                skid_err <= err_c;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed bench for imm_gen_pipe. A 32-bit and a 64-bit
// instance share every input so both widths see identical traffic.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [7:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [7:0]  out_tag64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready32),
        .instr(instr), .src(src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .src(src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one input beat and advance to just after the next rising edge.
    task automatic push(input logic [31:0] i, input logic [2:0] s, input logic [7:0] t);
        instr    = i;
        src      = s;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Reference immediate, written with signed-variable extension.
    function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] s);
        logic signed [11:0] v12;
        logic signed [12:0] v13;
        logic signed [20:0] v21;
        logic signed [31:0] v32;
        logic [63:0]        r;
        r = 64'd0;
        case (s)
            3'd0: begin v12 = i[31:20];                                   r = 64'(v12); end
            3'd1: begin v12 = {i[31:25], i[11:7]};                        r = 64'(v12); end
            3'd2: begin v13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};     r = 64'(v13); end
            3'd3: begin v21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};   r = 64'(v21); end
            3'd4: begin v32 = {i[31:12], 12'h000};                        r = 64'(v32); end
            3'd5: r = 64'(i[19:15]);
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] ri;
        logic [2:0]  rs;
        logic [63:0] exp;

        rst = 1'b1; in_valid = 1'b0; instr = '0; src = '0; in_tag = '0; out_ready = 1'b0;

        // Power-up reset.
        tick(); tick();
        check("rst_in_ready_low", 64'(in_ready32), 64'd0);
        rst = 1'b0;
        tick();
        check("rst_out_valid", 64'(out_valid32), 64'd0);
        check("rst_in_ready", 64'(in_ready32), 64'd1);
        check("rst_out_imm", 64'(out_imm32), 64'd0);
        check("rst_out_tag", 64'(out_tag32), 64'd0);
        check("rst_out_err", 64'(out_err32), 64'd0);

        // Formats at XLEN=32, one-cycle latency, back to back.
        out_ready = 1'b1;
        push(32'hA750_0000, 3'b000, 8'h01);
        check("fmt_i_valid", 64'(out_valid32), 64'd1);
        check("fmt_i_imm", 64'(out_imm32), 64'hFFFF_FA75);
        check("fmt_i_tag", 64'(out_tag32), 64'h01);
        push(32'hA600_0A80, 3'b001, 8'h02);
        check("fmt_s_imm", 64'(out_imm32), 64'hFFFF_FA75);
        push(32'hA600_0A80, 3'b010, 8'h03);
        check("fmt_b_imm", 64'(out_imm32), 64'hFFFF_FA74);
        push(32'hA600_0A80, 3'b011, 8'h04);
        check("fmt_j_imm", 64'(out_imm32), 64'hFFF0_0260);
        push(32'hA600_0A80, 3'b100, 8'h05);
        check("fmt_u_imm", 64'(out_imm32), 64'hA600_0000);
        check("fmt_u_tag", 64'(out_tag32), 64'h05);
        check("fmt_u_err", 64'(out_err32), 64'd0);

        // Zimm and illegal codes.
        push(32'h000F_8073, 3'b101, 8'h06);
        check("zimm_imm", 64'(out_imm32), 64'h1F);
        check("zimm_err", 64'(out_err32), 64'd0);
        push(32'hFFFF_FFFF, 3'b110, 8'h07);
        check("ill110_imm", 64'(out_imm32), 64'd0);
        check("ill110_err", 64'(out_err32), 64'd1);
        push(32'hFFFF_FFFF, 3'b111, 8'h08);
        check("ill111_err", 64'(out_err32), 64'd1);

        // XLEN=64 sign fill.
        push(32'h8000_0000, 3'b100, 8'h09);
        check("x64_u_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
        check("x32_u_imm", 64'(out_imm32), 64'h8000_0000);
        push(32'h8000_0000, 3'b000, 8'h0A);
        check("x64_i_imm", out_imm64, 64'hFFFF_FFFF_FFFF_F800);
        push(32'h000F_8073, 3'b101, 8'h0B);
        check("x64_z_imm", out_imm64, 64'h1F);

        // Drain, then wiggle the payload with in_valid low.
        in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(out_valid32), 64'd0);
        instr = 32'h1234_5678; src = 3'b011; in_tag = 8'hEE;
        tick(); tick();
        check("idle_no_effect", 64'(out_valid32), 64'd0);

        // Backpressure: two accepts fill the buffer, third is held off.
        out_ready = 1'b0;
        push(32'h0010_0000, 3'b000, 8'd1);
        check("bp_ready_after1", 64'(in_ready32), 64'd1);
        push(32'h0020_0000, 3'b000, 8'd2);
        check("bp_ready_after2", 64'(in_ready32), 64'd0);
        push(32'h0030_0000, 3'b000, 8'd3);
        check("bp_stall_tag", 64'(out_tag32), 64'd1);
        check("bp_stall_imm", 64'(out_imm32), 64'd1);
        tick();
        check("bp_stall_tag2", 64'(out_tag32), 64'd1);
        check("bp_stall_valid", 64'(out_valid32), 64'd1);
        out_ready = 1'b1;
        tick();
        check("bp_tag2", 64'(out_tag32), 64'd2);
        check("bp_imm2", 64'(out_imm32), 64'd2);
        check("bp_ready_reopen", 64'(in_ready32), 64'd1);
        tick();
        check("bp_tag3", 64'(out_tag32), 64'd3);
        check("bp_imm3", 64'(out_imm32), 64'd3);
        in_valid = 1'b0;
        tick();
        check("bp_empty", 64'(out_valid32), 64'd0);

        // Reset mid-stream with a full buffer.
        out_ready = 1'b0;
        push(32'h1230_0000, 3'b000, 8'h11);
        push(32'h4560_0000, 3'b000, 8'h22);
        rst = 1'b1;
        #1;
        check("mrst_in_ready_low", 64'(in_ready32), 64'd0);
        tick(); tick();
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("mrst_valid", 64'(out_valid32), 64'd0);
        check("mrst_imm", 64'(out_imm32), 64'd0);
        check("mrst_tag", 64'(out_tag32), 64'd0);
        check("mrst_in_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        push(32'h000F_8073, 3'b101, 8'h33);
        check("mrst_first_tag", 64'(out_tag32), 64'h33);
        in_valid = 1'b0;
        tick();
        check("mrst_no_stale", 64'(out_valid32), 64'd0);

        // Streaming: random payloads, one result per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            ri  = $urandom;
            rs  = 3'($urandom_range(0, 7));
            exp = model_imm(ri, rs);
            push(ri, rs, 8'(k + 8'h40));
            check($sformatf("st%0d_valid", k), 64'(out_valid32), 64'd1);
            check($sformatf("st%0d_imm32", k), 64'(out_imm32), 64'(exp[31:0]));
            check($sformatf("st%0d_imm64", k), out_imm64, exp);
            check($sformatf("st%0d_err", k), 64'(out_err32), 64'(rs >= 3'd6));
            check($sformatf("st%0d_tag", k), 64'(out_tag64), 64'(k + 8'h40));
        end
        in_valid = 1'b0;
        tick();
        check("st_end_empty", 64'(out_valid32), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
